frac_n_div_ctrl: RTL and testbench

Fractional-N divide-ratio controller for the PLL feedback divider. It counts input clock cycles and emits one `div_out` pulse per output period. A first-order (MASH-1) accumulator chooses a period of N or N+1 cycles, so the long-run average ratio is N + frac/2^FRAC_W. A valid/ready configuration port loads new N/frac values into shadow registers, and these take effect only at a period boundary, so the output never glitches.

---
 rtl/frac_n_div_ctrl.sv | 104 ++++++++++
 tb/tb_frac_n_div_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/frac_n_div_ctrl.sv
// Fractional-N feedback divider controller: first-order accumulator chooses N or N+1
// cycle periods, and a valid/ready port stages new ratios that are applied at a period boundary.
module frac_n_div_ctrl #(
    parameter int N_W    = 6,
    parameter int FRAC_W = 8,
    parameter int N_MIN  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [N_W-1:0]    cfg_n,
    input  logic [FRAC_W-1:0] cfg_frac,
    output logic              cfg_err,
    output logic              div_out,
    output logic [N_W:0]      cur_ratio,
    output logic              carry
);

    localparam logic [N_W-1:0] N_MIN_V = N_W'(N_MIN);

    logic [N_W-1:0]    n_act;
    logic [N_W-1:0]    shadow_n;
    logic [N_W-1:0]    cnt;
    logic [FRAC_W-1:0] frac_act;
    logic [FRAC_W-1:0] shadow_frac;
    logic [FRAC_W-1:0] acc;
    logic              pending;

    logic              boundary;
    logic              xfer;
    logic              cfg_ok;
    logic [N_W-1:0]    n_use;
    logic [FRAC_W-1:0] frac_use;
    logic [FRAC_W:0]   sum;
    logic [N_W:0]      ratio_next;
    logic [N_W-1:0]    cnt_reload;

    // One MASH-1 step: the extra top bit is the carry that stretches the period.
    function automatic logic [FRAC_W:0] mash1_step(input logic [FRAC_W-1:0] a,
                                                   input logic [FRAC_W-1:0] f);
        return {1'b0, a} + {1'b0, f};
    endfunction

    assign boundary   = en && (cnt == '0);
    assign xfer       = cfg_valid && cfg_ready;
    assign cfg_ok     = (cfg_n >= N_MIN_V);

    // A staged config replaces the active one before the boundary arithmetic uses it.
    assign n_use      = pending ? shadow_n : n_act;
    assign frac_use   = pending ? shadow_frac : frac_act;
    assign sum        = mash1_step(acc, frac_use);
    assign ratio_next = {1'b0, n_use} + {{N_W{1'b0}}, sum[FRAC_W]};
    assign cnt_reload = n_use + N_W'(sum[FRAC_W]) - N_W'(1);

    always_ff @(posedge clk) begin
        if (xfer && cfg_ok) begin
            shadow_n    <= cfg_n;
            shadow_frac <= cfg_frac;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_act     <= N_MIN_V;
            frac_act  <= '0;
            acc       <= '0;
            cnt       <= N_W'(N_MIN - 1);
            pending   <= 1'b0;
            div_out   <= 1'b0;
            cfg_ready <= 1'b1;
            cfg_err   <= 1'b0;
            cur_ratio <= (N_W+1)'(N_MIN);
            carry     <= 1'b0;
        end else begin
            div_out <= boundary;
            cfg_err <= xfer && !cfg_ok;

            if (boundary) begin
                if (pending) begin
                    n_act    <= shadow_n;
                    frac_act <= shadow_frac;
                end
                acc       <= sum[FRAC_W-1:0];
                carry     <= sum[FRAC_W];
                cur_ratio <= ratio_next;
                cnt       <= cnt_reload;
            end else if (en) begin
                cnt <= cnt - N_W'(1);
            end

            // A capture cannot coincide with an apply because ready is low while pending.
            if (xfer && cfg_ok) begin
                pending   <= 1'b1;
                cfg_ready <= 1'b0;
            end else if (boundary && pending) begin
                pending   <= 1'b0;
                cfg_ready <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_frac_n_div_ctrl.sv
// Bench for frac_n_div_ctrl: per-cycle comparison against a period-level reference model,
// a table of configurations with expected period/carry patterns, and handshake corner cases.
module tb_frac_n_div_ctrl;

    localparam int N_W    = 6;
    localparam int FRAC_W = 8;
    localparam int N_MIN  = 4;
    localparam int MODV   = 1 << FRAC_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [N_W-1:0]    cfg_n = '0;
    logic [FRAC_W-1:0] cfg_frac = '0;
    logic              cfg_err;
    logic              div_out;
    logic [N_W:0]      cur_ratio;
    logic              carry;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: active ratio/fraction, phase within the current period.
    int m_n, m_frac, m_acc, m_phase, m_ratio, m_carry, m_sn, m_sf;
    bit m_pend, e_div, e_err, e_ready;

    typedef struct packed {
        logic [5:0]      n;
        logic [7:0]      frac;
        logic            err;
        logic [3:0][6:0] per;
        logic [3:0]      car;
    } vec_t;

    vec_t vecs[7];

    frac_n_div_ctrl #(.N_W(N_W), .FRAC_W(FRAC_W), .N_MIN(N_MIN)) dut (
        .clk(clk), .rst(rst), .en(en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_n(cfg_n), .cfg_frac(cfg_frac), .cfg_err(cfg_err),
        .div_out(div_out), .cur_ratio(cur_ratio), .carry(carry)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(int n, int frac, bit err, int p0, int p1, int p2, int p3,
                                logic [3:0] car);
        vec_t v;
        v.n = 6'(n);
        v.frac = 8'(frac);
        v.err = err;
        v.per[0] = 7'(p0);
        v.per[1] = 7'(p1);
        v.per[2] = 7'(p2);
        v.per[3] = 7'(p3);
        v.car = car;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_n = N_MIN; m_frac = 0; m_acc = 0; m_phase = 0; m_ratio = N_MIN; m_carry = 0;
        m_pend = 0; e_div = 0; e_err = 0; e_ready = 1;
    endtask

    task automatic model_step();
        bit bnd, xf;
        int s;
        if (!rst) begin
            model_reset();
        end else begin
            bnd = en && (m_phase == m_ratio - 1);
            xf  = cfg_valid && e_ready;
            e_div = bnd;
            e_err = xf && (int'(cfg_n) < N_MIN);
            if (en) m_phase = bnd ? 0 : m_phase + 1;
            if (bnd) begin
                if (m_pend) begin
                    m_n = m_sn; m_frac = m_sf; m_pend = 0;
                end
                s = m_acc + m_frac;
                m_carry = (s >= MODV) ? 1 : 0;
                m_acc = s % MODV;
                m_ratio = m_n + m_carry;
            end
            if (xf && int'(cfg_n) >= N_MIN) begin
                m_sn = int'(cfg_n); m_sf = int'(cfg_frac); m_pend = 1;
            end
            e_ready = !m_pend;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("div_out", div_out, e_div);
        check("cur_ratio", cur_ratio, m_ratio);
        check("carry", carry, m_carry);
        check("cfg_ready", cfg_ready, e_ready);
        check("cfg_err", cfg_err, e_err);
    endtask

    // Cycles until the next div_out pulse; a missing pulse counts as a failure.
    task automatic gap(output int g);
        g = 0;
        do begin
            cycle();
            g++;
        end while (div_out !== 1'b1 && g < 200);
        if (div_out !== 1'b1) check("pulse_timeout", 0, 1);
    endtask

    task automatic do_reset();
        rst = 1'b0; en = 1'b1; cfg_valid = 1'b0;
        cycle();
        cycle();
        rst = 1'b1;
    endtask

    task automatic send(int n, int frac);
        cfg_valid = 1'b1; cfg_n = 6'(n); cfg_frac = 8'(frac);
        cycle();
        cfg_valid = 1'b0;
    endtask

    initial begin
        int g, tot;
        model_reset();
        vecs[0] = mk(7,   0, 0,  7,  7,  7,  7, 4'b0000);
        vecs[1] = mk(7, 128, 0,  7,  8,  7,  8, 4'b1010);
        vecs[2] = mk(7,  64, 0,  7,  7,  7,  8, 4'b1000);
        vecs[3] = mk(3,   0, 1,  4,  4,  4,  4, 4'b0000);
        vecs[4] = mk(63, 255, 0, 63, 64, 64, 64, 4'b1110);
        vecs[5] = mk(4, 255, 0,  4,  5,  5,  5, 4'b1110);
        vecs[6] = mk(10, 192, 0, 10, 11, 11, 11, 4'b1110);

        #1;
        do_reset();
        check("reset_ratio", cur_ratio, N_MIN);
        check("reset_ready", cfg_ready, 1);
        check("reset_div", div_out, 0);
        gap(g); check("first_pulse", g, N_MIN);
        gap(g); check("default_period", g, N_MIN);

        for (int i = 0; i < 7; i++) begin
            do_reset();
            send(vecs[i].n, vecs[i].frac);
            check("tbl_cfg_err", cfg_err, vecs[i].err);
            check("tbl_cfg_ready", cfg_ready, vecs[i].err);
            gap(g);
            for (int k = 0; k < 4; k++) begin
                check("tbl_carry", carry, vecs[i].car[k]);
                gap(g);
                check("tbl_period", g, vecs[i].per[k]);
            end
        end

        // Sixteen periods of 7.5 average
        do_reset();
        send(7, 128);
        gap(g);
        tot = 0;
        for (int k = 0; k < 16; k++) begin
            gap(g);
            tot += g;
        end
        check("avg16_total", tot, 120);

        // Transfer in the boundary cycle is applied one period later
        do_reset();
        gap(g);
        cycle(); cycle(); cycle();
        send(7, 0);
        check("coincident_pulse", div_out, 1);
        check("coincident_ready", cfg_ready, 0);
        gap(g); check("coincident_old", g, 4);
        gap(g); check("coincident_new", g, 7);

        // Request while not ready is ignored
        do_reset();
        send(7, 0);
        cfg_valid = 1'b1; cfg_n = 6'd9; cfg_frac = 8'd0;
        cycle(); cycle();
        cfg_valid = 1'b0;
        gap(g);
        check("ignored_ready_back", cfg_ready, 1);
        gap(g); check("ignored_period1", g, 7);
        gap(g); check("ignored_period2", g, 7);

        // Enable low for 5 cycles stretches the period by 5
        do_reset();
        gap(g);
        cycle();
        en = 1'b0;
        for (int k = 0; k < 5; k++) cycle();
        en = 1'b1;
        gap(g);
        check("en_hold_gap", g + 6, 9);

        // Reset mid-period drops a pending config
        do_reset();
        send(7, 0);
        cycle();
        rst = 1'b0;
        cycle();
        check("midrst_ready", cfg_ready, 1);
        check("midrst_ratio", cur_ratio, 4);
        rst = 1'b1;
        gap(g); check("midrst_first", g, 4);
        gap(g); check("midrst_period", g, 4);
        gap(g); check("midrst_period2", g, 4);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            rst       = ($urandom_range(0, 499) != 0);
            en        = ($urandom_range(0, 9) != 0);
            cfg_valid = ($urandom_range(0, 7) == 0);
            cfg_n     = 6'($urandom_range(0, 63));
            cfg_frac  = 8'($urandom_range(0, 255));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
